// File: rtl/lcd_text_responder.sv
// HD44780-style 8-bit character LCD receiver with DDRAM, address counter,
// display flags, busy-time model and a registered host read port.
module lcd_text_responder #(
  parameter int DDRAM_DEPTH  = 80,
  parameter int CMD_CYCLES   = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_data,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       cmd_valid,
  output logic       cmd_rs,
  output logic [7:0] cmd_byte,
  output logic       err_busy_write,
  output logic [6:0] addr_cnt,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_mode,
  output logic       shift_mode,
  output logic       dl_8bit
);

  localparam int WW = $clog2(CLEAR_CYCLES + 1);
  localparam logic [6:0] LAST = 7'(DDRAM_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WAIT} state_t;

  state_t          r_state;
  logic [6:0]      r_fill_idx;
  logic [WW-1:0]   r_wait_cnt;
  logic [7:0]      r_mem [DDRAM_DEPTH];

  logic            r_rs_m, r_rs_s, r_rs_d;
  logic            r_rw_m, r_rw_s, r_rw_d;
  logic            r_en_m, r_en_s, r_en_d;
  logic [7:0]      r_data_m, r_data_s, r_data_d;

  logic            w_strobe;
  logic            w_wr;
  logic            w_we;
  logic [6:0]      w_waddr;
  logic [7:0]      w_wdata;

  assign w_strobe = r_en_d & ~r_en_s;
  assign w_wr     = w_strobe & ~r_rw_d;

  function automatic logic [6:0] f_step(input logic [6:0] a,
                                        input logic       up);
    if (up) return (a == LAST) ? 7'd0 : a + 7'd1;
    else    return (a == 7'd0) ? LAST : a - 7'd1;
  endfunction

  // Two-flop synchronisers plus one delay stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_rs_m, r_rs_s, r_rs_d} <= '0;
      {r_rw_m, r_rw_s, r_rw_d} <= '0;
      {r_en_m, r_en_s, r_en_d} <= '0;
      r_data_m <= '0;
      r_data_s <= '0;
      r_data_d <= '0;
    end else begin
      r_rs_m   <= lcd_rs;   r_rs_s   <= r_rs_m;   r_rs_d   <= r_rs_s;
      r_rw_m   <= lcd_rw;   r_rw_s   <= r_rw_m;   r_rw_d   <= r_rw_s;
      r_en_m   <= lcd_en;   r_en_s   <= r_en_m;   r_en_d   <= r_en_s;
      r_data_m <= lcd_data; r_data_s <= r_data_m; r_data_d <= r_data_s;
    end
  end

  // Single DDRAM write port: fill pattern or an accepted data byte
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_fill_idx;
    w_wdata = 8'h20;
    if (r_state == S_FILL) begin
      w_we = 1'b1;
    end else if (!rst && r_state == S_IDLE && w_wr && r_rs_d) begin
      w_we    = 1'b1;
      w_waddr = addr_cnt;
      w_wdata = r_data_d;
    end
  end

  // DDRAM storage, no reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // Registered host read; out-of-range addresses read as zero
  always_ff @(posedge clk) begin
    if (rst) rd_data <= 8'h00;
    else if ({1'b0, rd_addr} < 8'(DDRAM_DEPTH)) rd_data <= r_mem[rd_addr];
    else rd_data <= 8'h00;
  end

  // Controller FSM: command decode, fill sequencing and busy timing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_FILL;
      r_fill_idx     <= 7'd0;
      r_wait_cnt     <= '0;
      busy           <= 1'b1;
      cmd_valid      <= 1'b0;
      cmd_rs         <= 1'b0;
      cmd_byte       <= 8'h00;
      err_busy_write <= 1'b0;
      addr_cnt       <= 7'd0;
      disp_on        <= 1'b0;
      cursor_on      <= 1'b0;
      blink_on       <= 1'b0;
      inc_mode       <= 1'b1;
      shift_mode     <= 1'b0;
      dl_8bit        <= 1'b1;
    end else begin
      cmd_valid      <= 1'b0;
      err_busy_write <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_wr) begin
            cmd_valid  <= 1'b1;
            cmd_rs     <= r_rs_d;
            cmd_byte   <= r_data_d;
            busy       <= 1'b1;
            r_state    <= S_WAIT;
            r_wait_cnt <= WW'(CMD_CYCLES);
            if (r_rs_d) begin
              addr_cnt <= f_step(addr_cnt, inc_mode);
            end else begin
              unique casez (r_data_d)
                8'b1???????: begin
                  if ({1'b0, r_data_d[6:0]} < 8'(DDRAM_DEPTH))
                    addr_cnt <= r_data_d[6:0];
                  else
                    addr_cnt <= 7'd0;
                end
                8'b01??????: begin
                end
                8'b001?????: dl_8bit <= r_data_d[4];
                8'b0001????: begin
                  if (!r_data_d[3])
                    addr_cnt <= f_step(addr_cnt, r_data_d[2]);
                end
                8'b00001???: begin
                  disp_on   <= r_data_d[2];
                  cursor_on <= r_data_d[1];
                  blink_on  <= r_data_d[0];
                end
                8'b000001??: begin
                  inc_mode   <= r_data_d[1];
                  shift_mode <= r_data_d[0];
                end
                8'b0000001?: begin
                  addr_cnt   <= 7'd0;
                  r_wait_cnt <= WW'(CLEAR_CYCLES);
                end
                8'b00000001: begin
                  addr_cnt   <= 7'd0;
                  inc_mode   <= 1'b1;
                  r_state    <= S_FILL;
                  r_fill_idx <= 7'd0;
                  r_wait_cnt <= WW'(CLEAR_CYCLES - DDRAM_DEPTH);
                end
                default: begin
                  busy    <= 1'b0;
                  r_state <= S_IDLE;
                end
              endcase
            end
          end
        end
        S_FILL: begin
          if (w_wr) err_busy_write <= 1'b1;
          r_fill_idx <= r_fill_idx + 7'd1;
          if (r_fill_idx == LAST) begin
            if (r_wait_cnt != '0) begin
              r_state <= S_WAIT;
            end else begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (w_wr) err_busy_write <= 1'b1;
          if (r_wait_cnt <= WW'(1)) begin
            r_wait_cnt <= '0;
            r_state    <= S_IDLE;
            busy       <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt - WW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_responder.sv
// Scoreboard bench for lcd_text_responder: directed LCD bus strobes,
// cmd_valid checked by a monitor, busy timing and DDRAM contents checked inline.
module tb_lcd_text_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic       lcd_en = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [6:0] rd_addr = 7'd0;
  logic [7:0] rd_data;
  logic       busy, cmd_valid, cmd_rs, err_busy_write;
  logic [7:0] cmd_byte;
  logic [6:0] addr_cnt;
  logic       disp_on, cursor_on, blink_on;
  logic       inc_mode, shift_mode, dl_8bit;

  int errors = 0;
  int checks = 0;
  int err_cnt = 0;
  int vld_cnt = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;

  lcd_text_responder #(
    .DDRAM_DEPTH(80), .CMD_CYCLES(8), .CLEAR_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .cmd_valid(cmd_valid), .cmd_rs(cmd_rs),
    .cmd_byte(cmd_byte), .err_busy_write(err_busy_write),
    .addr_cnt(addr_cnt), .disp_on(disp_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .inc_mode(inc_mode),
    .shift_mode(shift_mode), .dl_8bit(dl_8bit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every cmd_valid pulse must match the oldest expected strobe
  always @(negedge clk) begin
    if (!rst && cmd_valid) begin
      vld_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cmd_valid unexpected: got %0h expected none",
                 {cmd_rs, cmd_byte});
      end else begin
        mon_e = exp_q.pop_front();
        chk("cmd_valid byte", {23'd0, cmd_rs, cmd_byte}, {23'd0, mon_e});
      end
    end
    if (!rst && err_busy_write) err_cnt++;
  end

  task automatic send(input logic rs, input logic rw,
                      input logic [7:0] d, input bit acc);
    @(negedge clk);
    lcd_rs = rs;
    lcd_rw = rw;
    lcd_data = d;
    lcd_en = 1'b1;
    if (acc) exp_q.push_back({rs, d});
    repeat (2) @(negedge clk);
    lcd_en = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!cmd_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_valid) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no cmd_valid expected pulse", nm);
    end
  endtask

  task automatic meas_busy(input string nm, input int exp);
    int n = 0;
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk(nm, n, exp);
  endtask

  task automatic wr(input logic rs, input logic [7:0] d,
                    input int exp_busy, input string nm);
    send(rs, 1'b0, d, 1'b1);
    wait_valid(nm);
    meas_busy(nm, exp_busy);
  endtask

  task automatic rd(input logic [6:0] a, input logic [7:0] exp,
                    input string nm);
    rd_addr = a;
    @(negedge clk);
    chk(nm, rd_data, exp);
  endtask

  initial begin
    #1ms;
    $display("FAIL global timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    // 1: reset state and initial fill
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst busy", busy, 1);
    chk("rst cmd_valid", cmd_valid, 0);
    chk("rst rd_data", rd_data, 0);
    chk("rst addr", addr_cnt, 0);
    chk("rst flags", {disp_on, cursor_on, blink_on, shift_mode}, 0);
    chk("rst inc/dl", {inc_mode, dl_8bit}, 2'b11);
    meas_busy("fill busy", 80);
    rd(7'd0, 8'h20, "fill rd0");
    rd(7'd40, 8'h20, "fill rd40");
    rd(7'd79, 8'h20, "fill rd79");
    rd(7'd100, 8'h00, "rd out of range");

    // 2: init sequence
    wr(0, 8'h38, 8, "busy 0x38");
    wr(0, 8'h0F, 8, "busy 0x0F");
    wr(0, 8'h01, 100, "busy clear");
    wr(0, 8'h06, 8, "busy 0x06");
    chk("init dl", dl_8bit, 1);
    chk("init disp", {disp_on, cursor_on, blink_on}, 3'b111);
    chk("init inc", inc_mode, 1);
    chk("init addr", addr_cnt, 0);

    // 3: data writes
    wr(1, 8'h54, 8, "busy data T");
    wr(1, 8'h61, 8, "busy data a");
    rd(7'd0, 8'h54, "ddram0 T");
    rd(7'd1, 8'h61, "ddram1 a");
    rd(7'd2, 8'h20, "ddram2 blank");
    chk("addr after data", addr_cnt, 2);

    // 4: address set, wrap up, decrement mode wrap down
    wr(0, 8'hCF, 8, "busy set79");
    chk("addr set79", addr_cnt, 79);
    wr(1, 8'h21, 8, "busy data 79");
    rd(7'd79, 8'h21, "ddram79");
    chk("addr wrap up", addr_cnt, 0);
    wr(0, 8'h04, 8, "busy entry dec");
    wr(1, 8'h41, 8, "busy data 0");
    rd(7'd0, 8'h41, "ddram0 A");
    chk("addr wrap down", addr_cnt, 79);

    // extra decode corners
    wr(0, 8'hE0, 8, "busy set96");
    chk("addr out of range set", addr_cnt, 0);
    wr(0, 8'h14, 8, "busy cursor right");
    chk("cursor right", addr_cnt, 1);
    wr(0, 8'h10, 8, "busy cursor left");
    wr(0, 8'h10, 8, "busy cursor left2");
    chk("cursor left wrap", addr_cnt, 79);
    wr(0, 8'h1C, 8, "busy display shift");
    chk("display shift no move", addr_cnt, 79);
    wr(0, 8'h00, 0, "nop busy");
    wr(0, 8'h02, 100, "busy home");
    chk("home addr", addr_cnt, 0);

    // 5: write while busy, then read strobe
    wr(0, 8'h06, 8, "busy entry inc");
    wr(0, 8'h85, 8, "busy set5");
    err_cnt = 0;
    send(1, 1'b0, 8'h55, 1'b1);
    wait_valid("data 55");
    @(negedge clk);
    send(1, 1'b0, 8'h77, 1'b0);
    repeat (12) @(negedge clk);
    chk("busy write err", err_cnt, 1);
    chk("idle after busy write", busy, 0);
    rd(7'd5, 8'h55, "ddram5");
    rd(7'd6, 8'h20, "ddram6 unchanged");
    chk("addr after reject", addr_cnt, 6);
    vld_cnt = 0;
    send(0, 1'b1, 8'h01, 1'b0);
    repeat (10) @(negedge clk);
    chk("rw strobe ignored", vld_cnt, 0);
    chk("rw strobe busy", busy, 0);
    chk("rw strobe addr", addr_cnt, 6);

    // 6: reset in the middle of a clear fill
    send(0, 1'b0, 8'h01, 1'b1);
    wait_valid("clear before rst");
    repeat (30) @(negedge clk);
    chk("busy mid fill", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2 flags", {disp_on, cursor_on, blink_on}, 0);
    meas_busy("refill busy", 80);
    rd(7'd0, 8'h20, "refill rd0");
    rd(7'd5, 8'h20, "refill rd5");
    rd(7'd79, 8'h20, "refill rd79");

    chk("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
